// File: rtl/bram_access_ctrl_if.sv
// bram_access_ctrl_if: request, response and BRAM port signals of the access controller
interface bram_access_ctrl_if #(parameter int LINES = 8192);
  localparam int AW = $clog2(LINES);
  logic          req_valid;
  logic          req_ready;
  logic [31:0]   req_addr;
  logic          req_wr;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] bram_addr;
  logic          bram_en;
  logic [3:0]    bram_be;
  logic [31:0]   bram_wdata;
  logic [31:0]   bram_rdata;
  modport slave (
    input  req_valid, req_addr, req_wr, req_size, req_unsigned, req_wdata, rsp_ready, bram_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, bram_addr, bram_en, bram_be, bram_wdata
  );
  modport master (
    output req_valid, req_addr, req_wr, req_size, req_unsigned, req_wdata, rsp_ready, bram_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, bram_addr, bram_en, bram_be, bram_wdata
  );
endinterface

// File: rtl/bram_access_ctrl.sv
// bram_access_ctrl: byte/half/word load-store front end for a byte-enable BRAM with an in-order response FIFO
module bram_access_ctrl #(
  parameter int LINES      = 8192,
  parameter int RESP_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  bram_access_ctrl_if.slave bus
);
  localparam int AW = $clog2(LINES);
  localparam int PW = $clog2(RESP_DEPTH);
  localparam logic [PW:0] DEPTH = RESP_DEPTH[PW:0];
  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_t;
  logic        v_q, uns_q, wr_q, err_q;
  logic [1:0]  size_q, off_q;
  rsp_t        mem_q [RESP_DEPTH];
  logic [PW-1:0] wp_q, rp_q, wp_d, rp_d;
  logic [PW:0] cnt_q, cnt_d, occ;
  logic        accept, err, st, pop;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ld;
  rsp_t        push_v;
  always_comb begin
    occ = cnt_q + {{PW{1'b0}}, v_q};
    bus.req_ready = !rst && occ < DEPTH;
    accept = bus.req_valid && bus.req_ready;
    err = bus.req_size == 2'b11 || (bus.req_size == 2'b01 && bus.req_addr[0]) ||
          (bus.req_size == 2'b10 && |bus.req_addr[1:0]) || {2'b00, bus.req_addr[31:2]} >= 32'(LINES);
    bus.bram_en = accept && !err;
    bus.bram_addr = bus.bram_en ? bus.req_addr[2 +: AW] : '0;
    st = bus.bram_en && bus.req_wr;
    bus.bram_be = !st ? 4'b0000 : bus.req_size == 2'b00 ? 4'b0001 << bus.req_addr[1:0] :
                  bus.req_size == 2'b01 ? 4'b0011 << bus.req_addr[1:0] : 4'b1111;
    bus.bram_wdata = !st ? 32'h0 : bus.req_size == 2'b00 ? {4{bus.req_wdata[7:0]}} :
                     bus.req_size == 2'b01 ? {2{bus.req_wdata[15:0]}} : bus.req_wdata;
    // BRAM read data for the in-flight access is valid now, so the response is formed on push
    byte_v = bus.bram_rdata[{off_q, 3'b000} +: 8];
    half_v = off_q[1] ? bus.bram_rdata[31:16] : bus.bram_rdata[15:0];
    ld = size_q == 2'b00 ? {{24{!uns_q && byte_v[7]}}, byte_v} :
         size_q == 2'b01 ? {{16{!uns_q && half_v[15]}}, half_v} : bus.bram_rdata;
    push_v.data = (err_q || wr_q) ? 32'h0 : ld;
    push_v.err = err_q;
    bus.rsp_valid = !rst && cnt_q != '0;
    bus.rsp_rdata = bus.rsp_valid ? mem_q[rp_q].data : 32'h0;
    bus.rsp_err = bus.rsp_valid && mem_q[rp_q].err;
    pop = bus.rsp_valid && bus.rsp_ready;
    wp_d = wp_q + {{(PW-1){1'b0}}, v_q};
    rp_d = rp_q + {{(PW-1){1'b0}}, pop};
    cnt_d = cnt_q + {{PW{1'b0}}, v_q} - {{PW{1'b0}}, pop};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= 1'b0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      v_q   <= accept;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      if (v_q) mem_q[wp_q] <= push_v;
    end
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      size_q <= bus.req_size;
      off_q  <= bus.req_addr[1:0];
      uns_q  <= bus.req_unsigned;
      wr_q   <= bus.req_wr;
      err_q  <= err;
    end
  end
endmodule

// File: tb/tb_bram_access_ctrl.sv
// tb_bram_access_ctrl: directed vectors against a behavioural BRAM and an expected-response queue
module tb_bram_access_ctrl;
  localparam int LINES = 8192;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  bram_access_ctrl_if #(.LINES(LINES)) bus();
  bram_access_ctrl #(.LINES(LINES), .RESP_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  logic [31:0] ram [LINES];
  int n_chk = 0;
  int n_err = 0;
  int n_rsp = 0;
  logic [32:0] exp_q [$];
  always @(posedge clk)
    if (bus.bram_en) begin
      for (int b = 0; b < 4; b++)
        if (bus.bram_be[b]) ram[bus.bram_addr][8*b +: 8] <= bus.bram_wdata[8*b +: 8];
      bus.bram_rdata <= ram[bus.bram_addr];
    end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (bus.rsp_valid && bus.rsp_ready) begin
      n_rsp++;
      if (exp_q.size() == 0) chk("spurious_rsp", 32'(bus.rsp_valid), 32'h0);
      else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("rsp_err", 32'(bus.rsp_err), 32'(e[32]));
        chk("rsp_rdata", bus.rsp_rdata, e[31:0]);
      end
    end
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic wr, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                       input logic [31:0] wd, input logic [32:0] e, input logic en_e,
                       input logic [3:0] be_e, input logic [31:0] wd_e);
    bus.req_valid = 1'b1;
    bus.req_wr = wr;
    bus.req_size = sz;
    bus.req_unsigned = uns;
    bus.req_addr = a;
    bus.req_wdata = wd;
    #1;
    chk("req_ready", 32'(bus.req_ready), 32'h1);
    chk("bram_en", 32'(bus.bram_en), 32'(en_e));
    if (en_e) begin
      chk("bram_addr", 32'(bus.bram_addr), 32'(a[2 +: 13]));
      chk("bram_be", 32'(bus.bram_be), 32'(be_e));
      if (wr) chk("bram_wdata", bus.bram_wdata, wd_e);
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask
  initial begin
    int acc, c0;
    bus.req_valid = 1'b0;
    bus.req_wr = 1'b0;
    bus.req_size = 2'b10;
    bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h0;
    bus.req_wdata = 32'h0;
    bus.rsp_ready = 1'b0;
    bus.bram_rdata = 32'h0;
    idle(2);
    chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'h0);
    chk("rst_bram_en", 32'(bus.bram_en), 32'h0);
    chk("rst_bram_be", 32'(bus.bram_be), 32'h0);
    chk("rst_bram_addr", 32'(bus.bram_addr), 32'h0);
    chk("rst_bram_wdata", bus.bram_wdata, 32'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(bus.req_ready), 32'h1);
    bus.rsp_ready = 1'b1;
    issue(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, {1'b0, 32'h0}, 1, 4'b1111, 32'hDEADBEEF);
    idle(3);
    issue(0, 2'b10, 0, 32'h10, 32'h0, {1'b0, 32'hDEADBEEF}, 1, 4'b0000, 32'h0);
    chk("lat_t1_valid", 32'(bus.rsp_valid), 32'h0);
    idle(1);
    chk("lat_t2_valid", 32'(bus.rsp_valid), 32'h1);
    idle(2);
    issue(1, 2'b00, 0, 32'h13, 32'h00000080, {1'b0, 32'h0}, 1, 4'b1000, 32'h80808080);
    issue(0, 2'b00, 0, 32'h13, 32'h0, {1'b0, 32'hFFFFFF80}, 1, 4'b0000, 32'h0);
    issue(0, 2'b00, 1, 32'h13, 32'h0, {1'b0, 32'h00000080}, 1, 4'b0000, 32'h0);
    issue(0, 2'b01, 0, 32'h12, 32'h0, {1'b0, 32'hFFFF80AD}, 1, 4'b0000, 32'h0);
    issue(1, 2'b01, 0, 32'h16, 32'h00001234, {1'b0, 32'h0}, 1, 4'b1100, 32'h12341234);
    idle(4);
    c0 = n_rsp;
    issue(0, 2'b10, 0, 32'h10, 32'h0, {1'b0, 32'h80ADBEEF}, 1, 4'b0000, 32'h0);
    issue(0, 2'b01, 0, 32'h11, 32'h0, {1'b1, 32'h0}, 0, 4'b0000, 32'h0);
    issue(0, 2'b10, 0, LINES * 4, 32'h0, {1'b1, 32'h0}, 0, 4'b0000, 32'h0);
    issue(0, 2'b11, 0, 32'h14, 32'h0, {1'b1, 32'h0}, 0, 4'b0000, 32'h0);
    issue(0, 2'b00, 1, 32'h10, 32'h0, {1'b0, 32'h000000EF}, 1, 4'b0000, 32'h0);
    chk("b2b_rsp_3", 32'(n_rsp - c0), 32'd3);
    idle(2);
    chk("b2b_rsp_5", 32'(n_rsp - c0), 32'd5);
    for (int k = 0; k < 4; k++)
      issue(1, 2'b10, 0, 32'h20 + 4 * k, 32'h11111111 * (k + 1), {1'b0, 32'h0}, 1, 4'b1111,
            32'h11111111 * (k + 1));
    idle(3);
    bus.rsp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      bus.req_valid = 1'b1;
      bus.req_wr = 1'b0;
      bus.req_size = 2'b10;
      bus.req_addr = 32'h20 + 4 * acc;
      #1;
      if (bus.req_ready) begin
        exp_q.push_back({1'b0, 32'h11111111 * (acc + 1)});
        acc++;
      end
      @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
    chk("full_accepted", 32'(acc), 32'(DEPTH));
    chk("full_req_ready", 32'(bus.req_ready), 32'h0);
    chk("full_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    bus.rsp_ready = 1'b1;
    idle(6);
    chk("drain_req_ready", 32'(bus.req_ready), 32'h1);
    chk("drain_empty", 32'(exp_q.size()), 32'h0);
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++)
      issue(0, 2'b10, 0, 32'h20 + 4 * k, 32'h0, {1'b0, 32'h11111111 * (k + 1)}, 1, 4'b0000, 32'h0);
    idle(2);
    chk("pend_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_valid", 32'(bus.rsp_valid), 32'h0);
    chk("mid_rst_ready", 32'(bus.req_ready), 32'h0);
    idle(1);
    chk("mid_rst_valid_next", 32'(bus.rsp_valid), 32'h0);
    rst = 1'b0;
    #1;
    chk("rel_req_ready", 32'(bus.req_ready), 32'h1);
    bus.rsp_ready = 1'b1;
    idle(5);
    chk("no_stale_valid", 32'(bus.rsp_valid), 32'h0);
    issue(0, 2'b10, 0, 32'h24, 32'h0, {1'b0, 32'h22222222}, 1, 4'b0000, 32'h0);
    issue(0, 2'b01, 1, 32'h16, 32'h0, {1'b0, 32'h00001234}, 1, 4'b0000, 32'h0);
    idle(4);
    chk("final_empty", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/bram_access_ctrl.md
BRAM_ACCESS_CTRL -- requirements
Module: bram_access_ctrl

Interface
REQ-001 SHALL have parameter LINES, default 8192, meaning BRAM depth in 32-bit words.
REQ-002 SHALL have parameter RESP_DEPTH, default 4, meaning response FIFO entries (power of two, >=2).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port req_valid, input, 1, request present.
REQ-006 SHALL have port req_ready, output, 1, request accepted when req_valid & req_ready.
REQ-007 SHALL have port req_addr, input, 32, byte address.
REQ-008 SHALL have port req_wr, input, 1, 1 = store, 0 = load.
REQ-009 SHALL have port req_size, input, 2, 00 byte, 01 half, 10 word, 11 illegal.
REQ-010 SHALL have port req_unsigned, input, 1, load zero-extends when 1, sign-extends when 0.
REQ-011 SHALL have port req_wdata, input, 32, store data, right-aligned.
REQ-012 SHALL have port rsp_valid, output, 1, response present.
REQ-013 SHALL have port rsp_ready, input, 1, response consumed when rsp_valid & rsp_ready.
REQ-014 SHALL have port rsp_rdata, output, 32, load result, 0 for stores and errors.
REQ-015 SHALL have port rsp_err, output, 1, misaligned, illegal-size or out-of-range request.
REQ-016 SHALL have port bram_addr, output, clog2(LINES), word address to the byte-enable BRAM port.
REQ-017 SHALL have port bram_en, output, 1, BRAM port enable.
REQ-018 SHALL have port bram_be, output, 4, BRAM byte enables (all 0 for loads).
REQ-019 SHALL have port bram_wdata, output, 32, lane-aligned store data.
REQ-020 SHALL have port bram_rdata, input, 32, BRAM read data, valid one cycle after an enabled access.

Function
REQ-021 SHALL generate exactly one response per accepted request, in acceptance order.
REQ-022 SHALL derive occupancy as in-flight stage (0/1) plus FIFO count, and SHALL drive req_ready = !rst & (occupancy < RESP_DEPTH), with no combinational path from rsp_ready.
REQ-023 SHALL flag an error on any of: size 11; half with addr[0]=1; word with addr[1:0]!=0; addr[31:2] >= LINES.
REQ-024 SHALL, on an accepted error-free request, drive bram_en=1 and bram_addr=addr[2+:clog2(LINES)] combinationally in the acceptance cycle; otherwise bram_en=0.
REQ-025 SHALL, on a store, drive bram_be: byte 0001<<addr[1:0], half 0011<<addr[1:0], word 1111; loads drive 0000.
REQ-026 SHALL replicate store data across lanes: byte as 4 copies of wdata[7:0], half as 2 copies of wdata[15:0], word unchanged.
REQ-027 SHALL register size, offset, unsigned, wr and err in a one-entry in-flight stage at acceptance, and push that stage into the FIFO on the next cycle.
REQ-028 SHALL extract load data from bram_rdata in the push cycle: byte lane addr[1:0], half lane addr[1], then sign- or zero-extend to 32 bits.
REQ-029 SHALL give rsp_valid no earlier than two cycles after acceptance (accept at T, rsp_valid at T+2 if the FIFO was empty).
REQ-030 SHALL sustain one request per cycle while rsp_ready is held high.
REQ-031 SHALL handle simultaneous FIFO push and pop in one cycle without count change or data loss.
REQ-032 SHALL hold rsp_valid, rsp_rdata and rsp_err stable while rsp_valid & !rsp_ready.
REQ-033 SHALL wrap FIFO pointers modulo RESP_DEPTH.

Reset
REQ-034 SHALL, while rst=1, force req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, bram_en=0, bram_be=0, bram_addr=0 and bram_wdata=0.
REQ-035 SHALL, on rst mid-operation, discard the in-flight stage and all FIFO entries; BRAM contents are not reverted.
REQ-036 SHALL assert req_ready in the first cycle after rst deasserts.

Verification
REQ-037 SHALL cover store word 0xDEADBEEF @0x10, then load word @0x10: bram_be=1111, bram_addr=4; response rdata=0xDEADBEEF, err=0, at T+2.
REQ-038 SHALL cover store byte 0x80 @0x13, then signed and unsigned byte loads @0x13: bram_be=1000, wdata=0x80808080; responses 0xFFFFFF80 and 0x00000080.
REQ-039 SHALL cover half load @0x11 and word load @(LINES*4): bram_en=0, responses err=1, rdata=0, in order with surrounding valid requests.
REQ-040 SHALL cover rsp_ready=0 with continuous requests: exactly RESP_DEPTH requests accepted, then req_ready=0; release drains in order and req_ready reasserts.
REQ-041 SHALL cover back-to-back loads with rsp_ready=1: one response per cycle after initial 2-cycle latency.
REQ-042 SHALL cover rst asserted with 3 responses pending: rsp_valid=0 the next cycle, no stale response after release, and req_ready=1 the first cycle after release.
